// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG run-length stage and its neighbours.
//   ZRL_RUN / EOB_RUN   : run field carried by ZRL (15,0) and EOB (0,0) symbols
//   BLOCK_LEN_DEFAULT   : coefficients per 8x8 block
//   sym_t               : one symbol at the default field widths
//   state_t             : encoder control states
package jpeg_pkg;

  localparam int unsigned ZRL_RUN           = 15;
  localparam int unsigned EOB_RUN           = 0;
  localparam int unsigned BLOCK_LEN_DEFAULT = 64;
  localparam int unsigned RUN_W_DEFAULT     = 6;
  localparam int unsigned DATA_W_DEFAULT    = 8;

  typedef struct packed {
    logic [RUN_W_DEFAULT-1:0]  run;
    logic [DATA_W_DEFAULT-1:0] value;
    logic                      eob;
    logic                      last;
  } sym_t;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_ZRL = 2'd1,
    ST_EOB = 2'd2
  } state_t;

endpackage

// File: rtl/jpeg_sym_reg.sv
// Single-entry valid/ready holding register.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : write load_data into the slot (caller guarantees !valid || ready)
//   load_data  : word to hold
//   valid/data : slot contents, stable while valid && !ready
//   ready      : downstream accepts the held word
module jpeg_sym_reg #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data,
  input  logic         ready
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/jpeg_rle_stream.sv
// Streaming run-length encoder for one zig-zag ordered coefficient block.
//   in_valid/in_ready/in_data    : one coefficient per handshake
//   out_valid/out_ready          : symbol handshake
//   out_run/out_value            : zero-run and non-zero value (value 0 for ZRL/EOB)
//   out_eob/out_last             : symbol is EOB / symbol closes the block
//   blk_done                     : high in the cycle the out_last symbol handshakes
module jpeg_rle_stream
  import jpeg_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BLOCK_LEN = 64,
  parameter int unsigned RUN_W     = 6,
  parameter bit          ZRL_EN    = 1'b0,
  parameter bit          EOB_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RUN_W-1:0]  out_run,
  output logic [DATA_W-1:0] out_value,
  output logic              out_eob,
  output logic              out_last,
  output logic              blk_done
);

  localparam int unsigned IDX_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int unsigned SYM_W = RUN_W + DATA_W + 2;
  localparam logic [RUN_W-1:0] ZRL_R   = RUN_W'(ZRL_RUN);
  localparam logic [RUN_W-1:0] EOB_R   = RUN_W'(EOB_RUN);
  localparam logic [RUN_W-1:0] SIXTEEN = RUN_W'(16);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(BLOCK_LEN - 1);

  state_t              state_q, state_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic                lastp_q, lastp_d;

  logic                slot_free, is_last;
  logic                load, ld_eob, ld_last;
  logic [RUN_W-1:0]    ld_run;
  logic [DATA_W-1:0]   ld_val;
  logic [SYM_W-1:0]    sym_in, sym_out;

  assign slot_free = !out_valid || out_ready;
  assign is_last   = (idx_q == IDX_END);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      run_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      lastp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      lastp_q <= lastp_d;
    end
  end

  // With EOB_EN=0 a closing zero can only be accepted once the slot has been
  // released, so there is never a held symbol left to mark as last.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    idx_d    = idx_q;
    val_d    = val_q;
    lastp_d  = lastp_q;
    in_ready = 1'b0;
    load     = 1'b0;
    ld_run   = '0;
    ld_val   = '0;
    ld_eob   = 1'b0;
    ld_last  = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          idx_d = is_last ? '0 : idx_q + 1'b1;
          if (in_data == '0) begin
            if (is_last) begin
              run_d = '0;
              if (EOB_EN) state_d = ST_EOB;
            end else begin
              run_d = run_q + 1'b1;
            end
          end else if (ZRL_EN && run_q >= SIXTEEN) begin
            // Park the value; it is emitted after the remaining ZRLs.
            val_d   = in_data;
            lastp_d = is_last;
            load    = 1'b1;
            ld_run  = ZRL_R;
            run_d   = run_q - SIXTEEN;
            state_d = ST_ZRL;
          end else begin
            load    = 1'b1;
            ld_run  = run_q;
            ld_val  = in_data;
            ld_last = is_last;
            run_d   = '0;
          end
        end
      end
      ST_ZRL: begin
        if (slot_free) begin
          load = 1'b1;
          if (run_q >= SIXTEEN) begin
            ld_run = ZRL_R;
            run_d  = run_q - SIXTEEN;
          end else begin
            ld_run  = run_q;
            ld_val  = val_q;
            ld_last = lastp_q;
            run_d   = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_EOB: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_run  = EOB_R;
          ld_eob  = 1'b1;
          ld_last = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign sym_in = {ld_eob, ld_last, ld_run, ld_val};

  jpeg_sym_reg #(.W(SYM_W)) u_sym_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (sym_in),
    .valid     (out_valid),
    .data      (sym_out),
    .ready     (out_ready)
  );

  assign {out_eob, out_last, out_run, out_value} = sym_out;
  assign blk_done = out_valid && out_ready && out_last;

endmodule

// File: tb/tb_jpeg_rle_stream.sv
// Directed bench for jpeg_rle_stream: dut0 with ZRL disabled, dut1 with ZRL enabled.
// Symbols are captured as {eob, last, run[5:0], value[7:0]}.
module tb_jpeg_rle_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] iv, ordy, ir, ov, oeob, olast, bdone;
  logic [7:0] idat [2];
  logic [7:0] oval [2];
  logic [5:0] orun [2];

  jpeg_rle_stream #(.DATA_W(8), .BLOCK_LEN(64), .RUN_W(6), .ZRL_EN(1'b0), .EOB_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_run(orun[0]), .out_value(oval[0]),
    .out_eob(oeob[0]), .out_last(olast[0]), .blk_done(bdone[0])
  );

  jpeg_rle_stream #(.DATA_W(8), .BLOCK_LEN(64), .RUN_W(6), .ZRL_EN(1'b1), .EOB_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_run(orun[1]), .out_value(oval[1]),
    .out_eob(oeob[1]), .out_last(olast[1]), .blk_done(bdone[1])
  );

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          bd0 = 0, bd1 = 0, stall_err = 0;
  logic [15:0] held0 = '0;
  logic        held0_v = 1'b0;
  int          passed = 0, fails = 0, total = 0;

  // Capture handshaken symbols and check stability of a stalled dut0 symbol.
  always @(posedge clk) begin
    if (ov[0] && ordy[0]) q0.push_back({oeob[0], olast[0], orun[0], oval[0]});
    if (ov[1] && ordy[1]) q1.push_back({oeob[1], olast[1], orun[1], oval[1]});
    if (bdone[0]) bd0++;
    if (bdone[1]) bd1++;
    if (held0_v && (held0 !== {oeob[0], olast[0], orun[0], oval[0]} || ov[0] !== 1'b1))
      stall_err++;
    held0_v = ov[0] && !ordy[0] && rst_n;
    held0   = {oeob[0], olast[0], orun[0], oval[0]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int s, input logic [7:0] d, input bit rnd, output int waits);
    waits = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rnd) ordy[s] = 1'($urandom_range(0, 1));
      iv[s]   = 1'b1;
      idat[s] = d;
      #1;
      if (ir[s]) begin
        @(posedge clk);
        #1;
        iv[s] = 1'b0;
        return;
      end
      waits++;
    end
    iv[s] = 1'b0;
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int s, input int n, input bit rnd);
    for (int k = 0; k < 400; k++) begin
      if ((s == 0 ? q0.size() : q1.size()) >= n) break;
      @(negedge clk);
      if (rnd) ordy[s] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    ordy[s] = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  int         w, wsum, errs;
  logic [7:0] v;
  logic [15:0] exp_sym;

  initial begin
    rst_n   = 1'b0;
    iv      = '0;
    ordy    = 2'b11;
    idat[0] = '0;
    idat[1] = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_out_run", 32'(orun[0]), 32'd0);
    chk("rst_out_value", 32'(oval[0]), 32'd0);
    chk("rst_out_eob", 32'(oeob[0]), 32'd0);
    chk("rst_out_last", 32'(olast[0]), 32'd0);
    chk("rst_blk_done", 32'(bdone[0]), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(ir[0]), 32'd1);

    // Block: idx0=5, idx3=-2, rest zero
    for (int i = 0; i < 64; i++) begin
      v = (i == 0) ? 8'd5 : (i == 3) ? 8'hFE : 8'd0;
      send(0, v, 1'b0, w);
    end
    drain(0, 3, 1'b0);
    chk("t1_count", 32'(q0.size()), 32'd3);
    chk("t1_sym0", 32'(q0[0]), 32'h0005);
    chk("t1_sym1", 32'(q0[1]), 32'h02FE);
    chk("t1_eob", 32'(q0[2]), 32'hC000);
    chk("t1_blk_done", 32'(bd0), 32'd1);
    q0.delete(); bd0 = 0;

    // All-zero block
    wsum = 0;
    for (int i = 0; i < 64; i++) begin
      send(0, 8'd0, 1'b0, w);
      wsum += w;
    end
    drain(0, 1, 1'b0);
    chk("t2_in_ready_waits", 32'(wsum), 32'd0);
    chk("t2_count", 32'(q0.size()), 32'd1);
    chk("t2_eob", 32'(q0[0]), 32'hC000);
    chk("t2_blk_done", 32'(bd0), 32'd1);
    q0.delete(); bd0 = 0;

    // ZRL_EN=1: single 7 at idx 40
    wsum = 0;
    for (int i = 0; i < 64; i++) begin
      v = (i == 40) ? 8'd7 : 8'd0;
      send(1, v, 1'b0, w);
      wsum += w;
    end
    drain(1, 4, 1'b0);
    chk("t3_zrl_stall", 32'(wsum), 32'd2);
    chk("t3_count", 32'(q1.size()), 32'd4);
    chk("t3_zrl0", 32'(q1[0]), 32'h0F00);
    chk("t3_zrl1", 32'(q1[1]), 32'h0F00);
    chk("t3_val", 32'(q1[2]), 32'h0807);
    chk("t3_eob", 32'(q1[3]), 32'hC000);
    chk("t3_blk_done", 32'(bd1), 32'd1);

    // 63 zeros then 1 at idx 63, ZRL off
    for (int i = 0; i < 64; i++) begin
      v = (i == 63) ? 8'd1 : 8'd0;
      send(0, v, 1'b0, w);
    end
    drain(0, 1, 1'b0);
    chk("t4_count", 32'(q0.size()), 32'd1);
    chk("t4_sym", 32'(q0[0]), 32'h7F01);
    chk("t4_blk_done", 32'(bd0), 32'd1);
    q0.delete(); bd0 = 0;

    // Dense block with random backpressure
    stall_err = 0;
    for (int i = 0; i < 64; i++) begin
      v = 8'(i * 3 + 1);
      send(0, v, 1'b1, w);
    end
    drain(0, 64, 1'b1);
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      exp_sym = {1'b0, (i == 63), 6'd0, 8'(i * 3 + 1)};
      if (i >= q0.size() || q0[i] !== exp_sym) errs++;
    end
    chk("t5_count", 32'(q0.size()), 32'd64);
    chk("t5_order", 32'(errs), 32'd0);
    chk("t5_stable", 32'(stall_err), 32'd0);
    chk("t5_blk_done", 32'(bd0), 32'd1);
    q0.delete(); bd0 = 0;

    // Reset at idx 30 with a symbol held in the slot, then a fresh block
    for (int i = 0; i < 30; i++) begin
      v = (i == 29) ? 8'd9 : 8'd0;
      send(0, v, 1'b0, w);
    end
    @(negedge clk);
    ordy[0] = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_valid", 32'(ov[0]), 32'd0);
    rst_n   = 1'b1;
    ordy[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_residual", 32'(q0.size()), 32'd0);
    bd0 = 0;
    for (int i = 0; i < 64; i++) begin
      v = (i == 0) ? 8'd5 : (i == 3) ? 8'hFE : 8'd0;
      send(0, v, 1'b0, w);
    end
    drain(0, 3, 1'b0);
    chk("t6_count", 32'(q0.size()), 32'd3);
    chk("t6_sym0", 32'(q0[0]), 32'h0005);
    chk("t6_sym1", 32'(q0[1]), 32'h02FE);
    chk("t6_eob", 32'(q0[2]), 32'hC000);
    chk("t6_blk_done", 32'(bd0), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
